// File: rtl/neuron_train_ctrl_if.sv
// Bundle of sample-memory, neuron, result-memory and run-control signals
// between neuron_train_ctrl (master) and its surroundings (slave).
interface neuron_train_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic                     start;
    logic                     mode;
    logic        [ADDR_W-1:0] last_addr;
    logic                     mem_rd;
    logic        [ADDR_W-1:0] mem_addr;
    logic signed [6:0]        mem_x1;
    logic signed [6:0]        mem_x2;
    logic signed [1:0]        mem_t;
    logic                     n_start;
    logic signed [6:0]        n_x1;
    logic signed [6:0]        n_x2;
    logic signed [1:0]        n_tin;
    logic                     n_eof;
    logic                     n_eoi;
    logic                     n_updating;
    logic                     n_learned;
    logic signed [1:0]        n_tout;
    logic                     res_we;
    logic        [ADDR_W-1:0] res_addr;
    logic signed [1:0]        res_data;
    logic                     busy;
    logic                     done;
    logic                     converged;
    logic        [7:0]        epochs;

    modport master (
        input  start, mode, last_addr, mem_x1, mem_x2, mem_t,
               n_updating, n_learned, n_tout,
        output mem_rd, mem_addr, n_start, n_x1, n_x2, n_tin, n_eof, n_eoi,
               res_we, res_addr, res_data, busy, done, converged, epochs
    );

    modport slave (
        output start, mode, last_addr, mem_x1, mem_x2, mem_t,
               n_updating, n_learned, n_tout,
        input  mem_rd, mem_addr, n_start, n_x1, n_x2, n_tin, n_eof, n_eoi,
               res_we, res_addr, res_data, busy, done, converged, epochs
    );
endinterface

// File: rtl/neuron_train_ctrl.sv
// Sequencer driving the perceptron neuron through training epochs and
// inference passes from a sample memory, writing inference results out.
module neuron_train_ctrl #(
    parameter int ADDR_W     = 4,
    parameter int MAX_EPOCHS = 100
) (
    input  logic                clk,
    input  logic                rst,
    neuron_train_ctrl_if.master bus
);
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_KICK    = 4'd1;
    localparam logic [3:0] S_FETCH   = 4'd2;
    localparam logic [3:0] S_PRESENT = 4'd3;
    localparam logic [3:0] S_WAIT    = 4'd4;
    localparam logic [3:0] S_EOF1    = 4'd5;
    localparam logic [3:0] S_EOF2    = 4'd6;
    localparam logic [3:0] S_CAPTURE = 4'd7;
    localparam logic [3:0] S_EOI     = 4'd8;
    localparam logic [3:0] S_DONE    = 4'd9;

    localparam logic [7:0] EPOCH_LIMIT = 8'(MAX_EPOCHS);

    logic        [3:0]        state_q,    state_d;
    logic        [ADDR_W-1:0] cnt_q,      cnt_d;
    logic        [ADDR_W-1:0] last_q,     last_d;
    logic                     mode_q,     mode_d;
    logic signed [6:0]        x1_q,       x1_d;
    logic signed [6:0]        x2_q,       x2_d;
    logic signed [1:0]        tin_q,      tin_d;
    logic                     done_q,     done_d;
    logic                     conv_q,     conv_d;
    logic        [7:0]        epochs_q,   epochs_d;
    logic                     res_we_q,   res_we_d;
    logic        [ADDR_W-1:0] res_addr_q, res_addr_d;
    logic signed [1:0]        res_data_q, res_data_d;

    logic [7:0] epochs_inc;
    logic       at_last;

    assign epochs_inc = epochs_q + 8'd1;
    // Compare before incrementing so last_addr = all-ones never wraps early.
    assign at_last    = (cnt_q == last_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        mode_d     = mode_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        tin_d      = tin_q;
        done_d     = done_q;
        conv_d     = conv_q;
        epochs_d   = epochs_q;
        res_we_d   = 1'b0;
        res_addr_d = res_addr_q;
        res_data_d = res_data_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d   = bus.mode;
                    last_d   = bus.last_addr;
                    done_d   = 1'b0;
                    conv_d   = 1'b0;
                    epochs_d = 8'd0;
                    cnt_d    = '0;
                    state_d  = S_KICK;
                end
            end
            S_KICK:  state_d = S_FETCH;
            S_FETCH: state_d = S_PRESENT;
            S_PRESENT: begin
                x1_d    = bus.mem_x1;
                x2_d    = bus.mem_x2;
                tin_d   = mode_q ? 2'sd0 : bus.mem_t;
                state_d = mode_q ? S_CAPTURE : S_WAIT;
            end
            S_WAIT: begin
                if (!bus.n_updating) begin
                    if (at_last) begin
                        state_d = S_EOF1;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_EOF1: state_d = S_EOF2;
            S_EOF2: begin
                epochs_d = epochs_inc;
                if (bus.n_learned) begin
                    conv_d  = 1'b1;
                    state_d = S_DONE;
                end else if (epochs_inc >= EPOCH_LIMIT) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_CAPTURE: begin
                // Result write is registered, so the strobe appears one cycle later.
                res_we_d   = 1'b1;
                res_addr_d = cnt_q;
                res_data_d = bus.n_tout;
                if (at_last) begin
                    state_d = S_EOI;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EOI: state_d = S_DONE;
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_q     <= '0;
            mode_q     <= 1'b0;
            x1_q       <= '0;
            x2_q       <= '0;
            tin_q      <= '0;
            done_q     <= 1'b0;
            conv_q     <= 1'b0;
            epochs_q   <= 8'd0;
            res_we_q   <= 1'b0;
            res_addr_q <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            mode_q     <= mode_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            tin_q      <= tin_d;
            done_q     <= done_d;
            conv_q     <= conv_d;
            epochs_q   <= epochs_d;
            res_we_q   <= res_we_d;
            res_addr_q <= res_addr_d;
            res_data_q <= res_data_d;
        end
    end

    // Strobes decode straight from the state register; no input reaches an output.
    assign bus.mem_rd    = (state_q == S_FETCH);
    assign bus.mem_addr  = cnt_q;
    assign bus.n_start   = (state_q == S_KICK);
    assign bus.n_eof     = (state_q == S_EOF1) || (state_q == S_EOF2);
    assign bus.n_eoi     = (state_q == S_EOI);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.n_x1      = x1_q;
    assign bus.n_x2      = x2_q;
    assign bus.n_tin     = tin_q;
    assign bus.res_we    = res_we_q;
    assign bus.res_addr  = res_addr_q;
    assign bus.res_data  = res_data_q;
    assign bus.done      = done_q;
    assign bus.converged = conv_q;
    assign bus.epochs    = epochs_q;
endmodule

// File: tb/tb_neuron_train_ctrl.sv
// Randomized bench for neuron_train_ctrl: a reactive neuron/memory model
// plus run-level predictions of latency, fetch order, strobes and results.
module tb_neuron_train_ctrl;
    localparam int AW   = 4;
    localparam int MAXE = 3;
    localparam int NS   = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    neuron_train_ctrl_if #(.ADDR_W(AW)) bus ();

    neuron_train_ctrl #(.ADDR_W(AW), .MAX_EPOCHS(MAXE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [6:0] smp_x1 [NS];
    logic signed [6:0] smp_x2 [NS];
    logic signed [1:0] smp_t  [NS];
    logic signed [1:0] out_tab[NS];
    int                stall  [NS];

    bit  cur_mode = 1'b0;
    int  learn_ep = 1000;
    int  rd_q[$];
    int  wr_q[$];
    int  eof_n = 0;
    int  eoi_n = 0;
    int  rd_addr = 0;
    bit  upd_at[int];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic rand_tables(input int max_stall);
        for (int i = 0; i < NS; i++) begin
            smp_x1[i]  = 7'($urandom);
            smp_x2[i]  = 7'($urandom);
            smp_t[i]   = 2'($urandom);
            out_tab[i] = 2'($urandom);
            stall[i]   = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
        end
    endtask

    // Neuron + sample memory model: answers fetches, stalls, learned flag.
    always @(negedge clk) begin
        if (bus.mem_rd) begin
            rd_addr = int'(bus.mem_addr);
            rd_q.push_back(rd_addr);
            if (!cur_mode)
                for (int k = 0; k < stall[rd_addr]; k++) upd_at[cyc + 2 + k] = 1'b1;
        end
        if (bus.n_eof) eof_n++;
        if (bus.n_eoi) eoi_n++;
        if (bus.res_we) begin
            wr_q.push_back(int'({bus.res_addr, bus.res_data}));
            check_eq("infer_tin_zero", 32'(bus.n_tin), 32'd0);
        end
        if (upd_at.exists(cyc) != 0)
            check_eq("stall_hold", 32'({bus.n_x1, bus.n_x2, bus.n_tin}),
                     32'({smp_x1[rd_addr], smp_x2[rd_addr], smp_t[rd_addr]}));
        bus.n_updating = (upd_at.exists(cyc) != 0);
        bus.mem_x1     = smp_x1[rd_addr];
        bus.mem_x2     = smp_x2[rd_addr];
        bus.mem_t      = smp_t[rd_addr];
        bus.n_tout     = out_tab[rd_addr];
        if (bus.n_eof && (eof_n % 2 == 0)) bus.n_learned = (eof_n / 2 >= learn_ep);
        else                               bus.n_learned = 1'($urandom);
    end

    task automatic run_case(input string name, input bit md, input int la,
                            input int lep, input bit poke);
        int  n, s, e_exp, lat_exp, t0, k, idx;
        bit  conv_exp;
        rd_q.delete();
        wr_q.delete();
        upd_at.delete();
        eof_n    = 0;
        eoi_n    = 0;
        cur_mode = md;
        learn_ep = lep;
        n = la + 1;
        s = 0;
        for (int i = 0; i < n; i++) s += stall[i];
        if (md) begin
            e_exp    = 0;
            conv_exp = 1'b0;
            lat_exp  = 4 + 3 * n;
        end else begin
            conv_exp = (lep <= MAXE);
            e_exp    = conv_exp ? lep : MAXE;
            lat_exp  = 3 + e_exp * (3 * n + 2 + s);
        end

        @(negedge clk);
        bus.start     = 1'b1;
        bus.mode      = md;
        bus.last_addr = AW'(la);
        t0 = cyc;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.mode      = ~md;
        bus.last_addr = AW'($urandom);
        check_eq({name, "_kick"}, 32'({bus.busy, bus.n_start, bus.mem_rd, bus.done}), 32'b1100);

        k = 0;
        while (!bus.done && k < 5000) begin
            @(negedge clk);
            k++;
            if (poke) bus.start = (k == 3);
        end
        bus.start = 1'b0;
        if (!bus.done) begin
            check_eq({name, "_timeout"}, 32'(bus.done), 32'd1);
            return;
        end

        check_eq({name, "_latency"},   32'(cyc - t0),         32'(lat_exp));
        check_eq({name, "_busy_low"},  32'(bus.busy),         32'd0);
        check_eq({name, "_epochs"},    32'(bus.epochs),       32'(e_exp));
        check_eq({name, "_converged"}, 32'(bus.converged),    32'(conv_exp));
        check_eq({name, "_eof_cyc"},   32'(eof_n),            32'(2 * e_exp));
        check_eq({name, "_eoi_cyc"},   32'(eoi_n),            32'(md));

        check_eq({name, "_rd_count"}, 32'(rd_q.size()), 32'((md ? 1 : e_exp) * n));
        idx = 0;
        for (int e = 0; e < (md ? 1 : e_exp); e++)
            for (int a = 0; a < n; a++) begin
                if (idx < rd_q.size()) check_eq({name, "_rd_addr"}, 32'(rd_q[idx]), 32'(a));
                idx++;
            end

        check_eq({name, "_wr_count"}, 32'(wr_q.size()), 32'(md ? n : 0));
        if (md)
            for (int a = 0; a < n && a < wr_q.size(); a++)
                check_eq({name, "_wr_data"}, 32'(wr_q[a]), 32'({AW'(a), out_tab[a]}));
    endtask

    initial begin
        logic [7:0] stat;
        int k;
        rand_tables(0);
        bus.start     = 1'b1;
        bus.mode      = 1'b0;
        bus.last_addr = '0;
        rst           = 1'b1;

        repeat (2) @(negedge clk);
        check_eq("rst_ctrl_held", 32'({bus.mem_rd, bus.n_start, bus.busy, bus.done}), 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        stat = {bus.mem_rd, bus.n_start, bus.n_eof, bus.n_eoi,
                bus.res_we, bus.busy, bus.done, bus.converged};
        check_eq("rst_flags",  32'(stat), 32'd0);
        check_eq("rst_epochs", 32'(bus.epochs), 32'd0);
        check_eq("rst_nin",    32'({bus.n_x1, bus.n_x2, bus.n_tin}), 32'd0);
        check_eq("rst_res",    32'({bus.mem_addr, bus.res_addr, bus.res_data}), 32'd0);

        run_case("train_nostall", 1'b0, 3, 1, 1'b0);
        stall[1] = 2;
        run_case("train_stall", 1'b0, 3, 1, 1'b0);
        stall[1] = 0;
        run_case("epoch_limit", 1'b0, 3, 99, 1'b0);
        out_tab[0] = 2'sd1;
        out_tab[1] = -2'sd1;
        out_tab[2] = 2'sd1;
        run_case("infer_dir", 1'b1, 2, 1, 1'b0);
        rand_tables(2);
        run_case("ignored_start", 1'b0, 5, 2, 1'b1);
        run_case("single_train", 1'b0, 0, 2, 1'b0);
        run_case("single_infer", 1'b1, 0, 1, 1'b0);
        run_case("full_train", 1'b0, NS - 1, 2, 1'b0);
        run_case("full_infer", 1'b1, NS - 1, 1, 1'b1);

        for (int r = 0; r < 10; r++) begin
            rand_tables(2);
            run_case($sformatf("rand%0d", r), 1'($urandom), int'($urandom_range(0, NS - 1)),
                     int'($urandom_range(1, 5)), 1'($urandom));
        end

        // Reset while the sequencer is stalled in WAIT.
        rand_tables(0);
        stall[1] = 2;
        cur_mode = 1'b0;
        learn_ep = 1000;
        upd_at.delete();
        @(negedge clk);
        bus.start     = 1'b1;
        bus.mode      = 1'b0;
        bus.last_addr = AW'(3);
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (upd_at.exists(cyc) == 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("midrst_reached_wait", 32'(upd_at.exists(cyc) != 0), 32'd1);
        upd_at.delete();
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_state", 32'({bus.busy, bus.n_eof, bus.done, bus.mem_rd}), 32'd0);
        rst = 1'b0;
        stall[1] = 0;
        run_case("after_rst", 1'b0, 3, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=finished", cyc);
        $fatal(1, "timeout");
    end
endmodule
